// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write-side arbiter:
//   state_t   - arbiter FSM encoding (IDLE=0, HDR=1, BURST=2)
//   HDR_MAGIC - marker byte placed at the top of a header beat
//   clog2     - ceiling log2 for sizing parameters
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Searches req starting at rr_ptr+1
// (mod N) and returns the first set index.
// Ports:
//   req     in  N    request vector
//   rr_ptr  in  IDW  last served index (search starts just after it)
//   valid   out 1    at least one request is set
//   index   out IDW  chosen requester
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] rr_ptr,
  output logic           valid,
  output logic [IDW-1:0] index
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] req_shift;
  logic [N-1:0]   req_rot;
  logic [IDW:0]   start;
  logic [IDW:0]   sum;
  logic [IDW-1:0] offset;

  // Rotate the request vector so that bit 0 is requester rr_ptr+1. A start
  // of N (rr_ptr = N-1) shifts the doubled vector by exactly one copy.
  assign req_dbl   = {req, req};
  assign start     = {1'b0, rr_ptr} + 1'b1;
  assign req_shift = req_dbl >> start;
  assign req_rot   = req_shift[N-1:0];

  // Lowest set bit of the rotated vector is the nearest requester.
  always_comb begin
    valid  = 1'b0;
    offset = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        valid  = 1'b1;
        offset = IDW'(k);
      end
    end
  end

  // Undo the rotation: start + offset lies in [1, 2N-1], so one conditional
  // subtraction is enough for the modulo.
  assign sum   = start + {1'b0, offset};
  assign index = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : IDW'(sum);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port among N requesters. A grant
// lasts for one burst, which ends on req_last or after BURST_MAX beats. Every
// burst is followed by at least one IDLE cycle. fifo_prog_full only blocks new
// grants; fifo_wfull stalls the current burst.
//
// Optional feature: define FIFO_ARB_HDR_EN to insert a header beat
// {HDR_MAGIC, zeros, grant_id} before each burst (needs DSIZE >= 8+IDW).
//
// Ports:
//   wclk            in   1        write-domain clock
//   wrst_n          in   1        asynchronous active-low reset
//   req_valid       in   N        requester i has a beat
//   req_data        in   N*DSIZE  beat data, slice i = [i*DSIZE +: DSIZE]
//   req_last        in   N        beat is last of requester i's packet
//   req_ready       out  N        beat accepted this cycle (one-hot or zero)
//   fifo_wreq       out  1        FIFO write request
//   fifo_wdata      out  DSIZE    FIFO write data
//   fifo_wfull      in   1        FIFO full
//   fifo_prog_full  in   1        FIFO programmable-full
//   grant_id        out  IDW      current / last granted requester
//   busy            out  1        arbiter not idle
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int DSIZE     = 32,
  parameter int BURST_MAX = 8,
  parameter int IDW       = clog2(N)
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic [N-1:0]       req_valid,
  input  logic [N*DSIZE-1:0] req_data,
  input  logic [N-1:0]       req_last,
  output logic [N-1:0]       req_ready,
  output logic               fifo_wreq,
  output logic [DSIZE-1:0]   fifo_wdata,
  input  logic               fifo_wfull,
  input  logic               fifo_prog_full,
  output logic [IDW-1:0]     grant_id,
  output logic               busy
);

  localparam int              CNTW     = clog2(BURST_MAX + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BURST_MAX - 1);

  state_t          state_reg, state_next;
  logic [CNTW-1:0] beat_cnt_reg, beat_cnt_next;
  logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]  grant_id_reg, grant_id_next;

  logic            pick_valid;
  logic [IDW-1:0]  pick_idx;
  logic [DSIZE-1:0] grant_data;
  logic            grant_valid;
  logic            grant_last;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_rr_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_reg),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  // Zero-latency data path from the granted requester.
  assign grant_data  = req_data[grant_id_reg*DSIZE +: DSIZE];
  assign grant_valid = req_valid[grant_id_reg];
  assign grant_last  = req_last[grant_id_reg];

`ifdef FIFO_ARB_HDR_EN
  logic [DSIZE-1:0] hdr_word;

  always_comb begin
    hdr_word               = '0;
    hdr_word[DSIZE-1 -: 8] = HDR_MAGIC;
    hdr_word[IDW-1:0]      = grant_id_reg;
  end
`endif

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_reg    <= ST_IDLE;
      beat_cnt_reg <= '0;
      rr_ptr_reg   <= IDW'(N - 1);   // requester 0 wins the first search
      grant_id_reg <= '0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      rr_ptr_reg   <= rr_ptr_next;
      grant_id_reg <= grant_id_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    rr_ptr_next   = rr_ptr_reg;
    grant_id_next = grant_id_reg;
    req_ready     = '0;
    fifo_wreq     = 1'b0;
    fifo_wdata    = grant_data;

    case (state_reg)
      ST_IDLE: begin
        // Grants are only decided here, so every burst costs one idle cycle.
        if (pick_valid && !fifo_prog_full) begin
          grant_id_next = pick_idx;
          beat_cnt_next = '0;
`ifdef FIFO_ARB_HDR_EN
          state_next    = ST_HDR;
`else
          state_next    = ST_BURST;
`endif
        end
      end

`ifdef FIFO_ARB_HDR_EN
      ST_HDR: begin
        // Header beat is not counted toward BURST_MAX.
        fifo_wdata = hdr_word;
        if (!fifo_wfull) begin
          fifo_wreq  = 1'b1;
          state_next = ST_BURST;
        end
      end
`endif

      ST_BURST: begin
        req_ready[grant_id_reg] = !fifo_wfull;
        if (grant_valid && !fifo_wfull) begin
          fifo_wreq = 1'b1;
          if (grant_last || (beat_cnt_reg == CNT_LAST)) begin
            state_next    = ST_IDLE;
            rr_ptr_next   = grant_id_reg;
            beat_cnt_next = '0;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign grant_id = grant_id_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Bench for fifo_wr_arbiter (N=4, DSIZE=32, BURST_MAX=8). Producers are
// packet queues; a rule-level model tracks who should own the write port,
// which beat must appear next and when grants happen. Directed scenarios
// run first, then a randomized stress phase.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N         = 4;
  localparam int DSIZE     = 32;
  localparam int BURST_MAX = 8;
  localparam int IDW       = 2;
  localparam int QDEPTH    = 256;

  logic               wclk = 1'b0;
  logic               wrst_n;
  logic [N-1:0]       req_valid;
  logic [N*DSIZE-1:0] req_data;
  logic [N-1:0]       req_last;
  logic [N-1:0]       req_ready;
  logic               fifo_wreq;
  logic [DSIZE-1:0]   fifo_wdata;
  logic               fifo_wfull;
  logic               fifo_prog_full;
  logic [IDW-1:0]     grant_id;
  logic               busy;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .N         (N),
    .DSIZE     (DSIZE),
    .BURST_MAX (BURST_MAX),
    .IDW       (IDW)
  ) dut (
    .wclk           (wclk),
    .wrst_n         (wrst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_last       (req_last),
    .req_ready      (req_ready),
    .fifo_wreq      (fifo_wreq),
    .fifo_wdata     (fifo_wdata),
    .fifo_wfull     (fifo_wfull),
    .fifo_prog_full (fifo_prog_full),
    .grant_id       (grant_id),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Producer packet storage: bit DSIZE is the last flag.
  logic [DSIZE:0] beat_mem [N][QDEPTH];
  int wr_p [N];
  int rd_p [N];
  int serial  = 0;
  int n_added = 0;
  int n_wr    = 0;

  // Stimulus knobs.
  int valid_pct  = 100;
  int wfull_pct  = 0;
  int pf_pct     = 0;
  bit force_wfull = 1'b0;
  bit force_pf    = 1'b0;

  // Reference model: owner of the port and beats sent in the current burst.
  bit m_busy;
  int m_grant;
  int m_cnt;
  int last_served;
  int grant_log [$];
  int len_log   [$];

  // Values observed at the last sample, for directed checks.
  logic           obs_wreq;
  logic [N-1:0]   obs_ready;
  logic [N-1:0]   acc;

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      wr_p[i] = 0;
      rd_p[i] = 0;
    end
    grant_log.delete();
    len_log.delete();
  endtask

  task automatic add_packet(input int r, input int len);
    for (int b = 0; b < len; b++) begin
      beat_mem[r][wr_p[r]] = {(b == len - 1), 4'(r), 28'(serial)};
      wr_p[r]++;
      serial++;
      n_added++;
    end
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) begin
      if (rd_p[i] != wr_p[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Called just after a rising edge (or reset release).
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rd_p[i] < wr_p[i]) begin
        req_valid[i]                = ($urandom_range(99) < valid_pct);
        req_data[i*DSIZE +: DSIZE]  = beat_mem[i][rd_p[i]][DSIZE-1:0];
        req_last[i]                 = beat_mem[i][rd_p[i]][DSIZE];
      end else begin
        req_valid[i]                = 1'b0;
        req_data[i*DSIZE +: DSIZE]  = '0;
        req_last[i]                 = 1'b0;
      end
    end
    fifo_wfull     = force_wfull || ($urandom_range(99) < wfull_pct);
    fifo_prog_full = force_pf    || ($urandom_range(99) < pf_pct);
  endtask

  // Called at the falling edge: compare against the model, then advance it
  // to what must hold after the coming rising edge.
  task automatic sample();
    logic [N-1:0] exp_ready;
    logic         exp_wreq;
    logic [DSIZE:0] head;
    exp_ready = '0;
    exp_wreq  = 1'b0;
    acc       = '0;
    obs_wreq  = fifo_wreq;
    obs_ready = req_ready;
    head      = '0;

    check_eq("busy", busy, m_busy);
    check_eq("grant_id", grant_id, m_grant);
    if (m_busy && !fifo_wfull) exp_ready[m_grant] = 1'b1;
    if (m_busy) exp_wreq = req_valid[m_grant] && !fifo_wfull;
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("fifo_wreq", fifo_wreq, exp_wreq);

    if (exp_wreq) begin
      head = beat_mem[m_grant][rd_p[m_grant]];
      check_eq("fifo_wdata", fifo_wdata, head[DSIZE-1:0]);
      acc[m_grant] = 1'b1;
      n_wr++;
      m_cnt++;
      if (head[DSIZE] || m_cnt == BURST_MAX) begin
        m_busy      = 1'b0;
        last_served = m_grant;
        len_log.push_back(m_cnt);
      end
    end else if (!m_busy && (req_valid != '0) && !fifo_prog_full) begin
      for (int k = 1; k <= N; k++) begin
        if (req_valid[(last_served + k) % N]) begin
          m_grant = (last_served + k) % N;
          break;
        end
      end
      m_busy = 1'b1;
      m_cnt  = 0;
      grant_log.push_back(m_grant);
    end
  endtask

  task automatic cycle();
    drive();
    @(negedge wclk);
    sample();
    @(posedge wclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) rd_p[i]++;
    end
  endtask

  task automatic apply_reset();
    wrst_n = 1'b0;
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_grant_id", grant_id, '0);
    check_eq("rst_req_ready", req_ready, '0);
    check_eq("rst_fifo_wreq", fifo_wreq, 1'b0);
    m_busy      = 1'b0;
    m_grant     = 0;
    m_cnt       = 0;
    last_served = N - 1;
    repeat (2) @(posedge wclk);
    #1;
    wrst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int cyc;
    cyc = 0;
    while ((!queues_empty() || m_busy) && cyc < budget) begin
      cycle();
      cyc++;
    end
    check_eq(tag, (cyc >= budget), 1'b0);
  endtask

  task automatic check_logs(input string tag, input int exp_g [], input int exp_l []);
    check_eq({tag, "_ngrants"}, grant_log.size(), exp_g.size());
    for (int k = 0; k < exp_g.size() && k < grant_log.size(); k++)
      check_eq({tag, "_grant"}, grant_log[k], exp_g[k]);
    for (int k = 0; k < exp_l.size() && k < len_log.size(); k++)
      check_eq({tag, "_len"}, len_log[k], exp_l[k]);
  endtask

  initial begin
    int eg [];
    int el [];
    int guard;
    wrst_n         = 1'b1;
    req_valid      = '0;
    req_data       = '0;
    req_last       = '0;
    fifo_wfull     = 1'b0;
    fifo_prog_full = 1'b0;
    clear_queues();
    #2;
    apply_reset();

`ifdef FIFO_ARB_HDR_EN
    // Header beat precedes the data beats of requester 3.
    req_valid = 4'b1000;
    req_data[3*DSIZE +: DSIZE] = 32'h3333_0001;
    req_last  = 4'b0000;
    @(negedge wclk);
    check_eq("hdr_idle_busy", busy, 1'b0);
    @(posedge wclk); #1;
    @(negedge wclk);
    check_eq("hdr_busy", busy, 1'b1);
    check_eq("hdr_grant", grant_id, 2'd3);
    check_eq("hdr_wreq", fifo_wreq, 1'b1);
    check_eq("hdr_wdata", fifo_wdata, 32'hA500_0003);
    check_eq("hdr_ready", req_ready, 4'b0000);
    @(posedge wclk); #1;
    @(negedge wclk);
    check_eq("hdr_d1_wreq", fifo_wreq, 1'b1);
    check_eq("hdr_d1_wdata", fifo_wdata, 32'h3333_0001);
    check_eq("hdr_d1_ready", req_ready, 4'b1000);
    @(posedge wclk); #1;
    req_data[3*DSIZE +: DSIZE] = 32'h3333_0002;
    req_last  = 4'b1000;
    @(negedge wclk);
    check_eq("hdr_d2_wdata", fifo_wdata, 32'h3333_0002);
    @(posedge wclk); #1;
    req_valid = '0;
    @(negedge wclk);
    check_eq("hdr_end_busy", busy, 1'b0);
`else
    // 1: requesters 0 and 2, two 2-beat packets each.
    add_packet(0, 2); add_packet(0, 2);
    add_packet(2, 2); add_packet(2, 2);
    drain("t1_timeout", 100);
    eg = '{0, 2, 0, 2}; el = '{2, 2, 2, 2};
    check_logs("t1", eg, el);

    // 2: one 20-beat packet splits into 8, 8, 4.
    clear_queues();
    add_packet(1, 20);
    drain("t2_timeout", 200);
    eg = '{1, 1, 1}; el = '{8, 8, 4};
    check_logs("t2", eg, el);

    // 3: prog_full blocks grants; release grants 0; then strict rotation.
    apply_reset();
    clear_queues();
    for (int r = 0; r < N; r++) begin
      add_packet(r, 1); add_packet(r, 1);
    end
    force_pf = 1'b1;
    repeat (5) cycle();
    check_eq("t3_pf_busy", busy, 1'b0);
    force_pf = 1'b0;
    cycle();
    check_eq("t3_rel_busy", busy, 1'b1);
    check_eq("t3_rel_grant", grant_id, 2'd0);
    drain("t3_timeout", 200);
    eg = '{0, 1, 2, 3, 0, 1, 2, 3}; el = '{1, 1, 1, 1, 1, 1, 1, 1};
    check_logs("t3", eg, el);

    // 4: wfull held 3 cycles after 2 beats of a 6-beat burst.
    clear_queues();
    add_packet(0, 6);
    guard = 0;
    while (!(m_busy && m_cnt == 2) && guard < 20) begin
      cycle();
      guard++;
    end
    check_eq("t4_reach", (guard >= 20), 1'b0);
    force_wfull = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check_eq("t4_stall_wreq", obs_wreq, 1'b0);
      check_eq("t4_stall_ready", obs_ready, 4'b0000);
    end
    force_wfull = 1'b0;
    drain("t4_timeout", 100);
    eg = '{0}; el = '{6};
    check_logs("t4", eg, el);

    // 5: reset after 3 beats of requester 2; requester 0 wins afterwards.
    clear_queues();
    apply_reset();
    add_packet(2, 10);
    guard = 0;
    while (!(m_busy && m_cnt == 3) && guard < 20) begin
      cycle();
      guard++;
    end
    check_eq("t5_reach", (guard >= 20), 1'b0);
    apply_reset();
    grant_log.delete();
    len_log.delete();
    add_packet(0, 2);
    cycle();
    check_eq("t5_busy", busy, 1'b1);
    check_eq("t5_first_grant", grant_id, 2'd0);
    drain("t5_timeout", 200);
    check_eq("t5_log_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Randomized stress: random packets, valid gaps, wfull and prog_full.
    clear_queues();
    apply_reset();
    valid_pct = 70;
    wfull_pct = 15;
    pf_pct    = 20;
    for (int r = 0; r < N; r++) begin
      for (int p = 0; p < 6; p++) add_packet(r, $urandom_range(20, 1));
    end
    drain("rand_timeout", 20000);
    check_eq("beats_written", n_wr, n_added);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
